mc_control_fsm: RTL and testbench

Parametrised multicycle control unit for the RISC-V multicycle CPU; successor to the fixed 16-state controller. It sequences fetch/decode/execute/memory/writeback per RV32I/RV64I base opcode and adds a memory-ready handshake with a wait-state timeout. It also provides a sticky trap on illegal opcode or funct3, an instruction-boundary halt request and a retired-instruction counter. It sits between the instruction register and the datapath muxes, register file, ALU and memory.

---
 rtl/mc_pkg.sv | 57 +++++
 rtl/mc_wait_timer.sv | 27 ++
 rtl/mc_control_fsm.sv | 197 +++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit: state codes, opcodes,
// immediate-select codes and trap causes.
package mc_pkg;

    typedef enum logic [4:0] {
        S_BOOT     = 5'd0,
        S_FETCH    = 5'd1,
        S_DECODE   = 5'd2,
        S_MEM_ADDR = 5'd3,
        S_MEM_RD   = 5'd4,
        S_LD_WB    = 5'd5,
        S_MEM_WR   = 5'd6,
        S_R_EX     = 5'd7,
        S_ALU_WB   = 5'd8,
        S_BR_EX    = 5'd9,
        S_JAL_EX   = 5'd10,
        S_JALR_EX  = 5'd11,
        S_LINK_WB  = 5'd12,
        S_I_EX     = 5'd13,
        S_U_EX     = 5'd14,
        S_U_WB     = 5'd15,
        S_HALTED   = 5'd16,
        S_TRAP     = 5'd17
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] CC_NONE  = 3'b000;
    localparam logic [2:0] CC_U     = 3'b001;
    localparam logic [2:0] CC_J     = 3'b010;
    localparam logic [2:0] CC_I     = 3'b011;
    localparam logic [2:0] CC_B     = 3'b100;
    localparam logic [2:0] CC_S     = 3'b101;
    localparam logic [2:0] CC_SHAMT = 3'b110;

    localparam logic [1:0] TC_NONE    = 2'b00;
    localparam logic [1:0] TC_OPCODE  = 2'b01;
    localparam logic [1:0] TC_FUNCT3  = 2'b10;
    localparam logic [1:0] TC_TIMEOUT = 2'b11;

    // Doubleword accesses (and unsigned word loads) exist only on RV64.
    function automatic logic ls_funct3_ok(input logic is_store, input logic [2:0] f3,
                                          input logic rv64);
        if (is_store)
            return (f3[2] == 1'b0) && ((f3[1:0] != 2'b11) || rv64);
        return (f3 != 3'b111) && ((f3 != 3'b110) || rv64) && ((f3 != 3'b011) || rv64);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter; flags when TIMEOUT idle cycles have elapsed.
module mc_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (tick && !expired)
            count <= count + WAIT_W'(1);
    end

    // TIMEOUT of zero never expires; the counter is then don't-care.
    assign expired = (TIMEOUT != 0) && (count == WAIT_W'(TIMEOUT));

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I/RV64I control unit with memory handshake, sticky trap,
// boundary halt and retired-instruction counter.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic              mem_ready,
    input  logic              halt_req,
    output logic              PCWrite,
    output logic              IRWrite,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              RegWrite,
    output logic              MemtoReg,
    output logic              RegDst,
    output logic              ALUSrc1,
    output logic              ALUSrc2,
    output logic              Jump,
    output logic              Branch,
    output logic              JALorJALR,
    output logic [6:0]        ALUOp,
    output logic [2:0]        Concat_control,
    output logic [XLEN/8-1:0] BE,
    output logic [4:0]        state,
    output logic              halted,
    output logic              trap,
    output logic [1:0]        trap_cause,
    output logic [CNT_W-1:0]  instret
);
    localparam logic RV64 = (XLEN == 64);

    state_t     cur, nxt;
    logic [1:0] trap_nxt;
    logic       complete;
    logic       expired;

    function automatic logic [XLEN/8-1:0] be_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = RV64 ? 8'hFF : 8'h00;
        endcase
        return m[XLEN/8-1:0];
    endfunction

    mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .clear   (nxt != cur),
        .tick    ((cur inside {S_FETCH, S_MEM_RD, S_MEM_WR}) && !mem_ready),
        .expired (expired)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cur        <= S_BOOT;
            trap_cause <= TC_NONE;
            instret    <= '0;
        end else begin
            cur <= nxt;
            if (trap_nxt != TC_NONE)
                trap_cause <= trap_nxt;
            if (complete)
                instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        nxt      = cur;
        trap_nxt = TC_NONE;
        complete = 1'b0;
        case (cur)
            S_BOOT:   nxt = S_FETCH;
            S_FETCH:
                if (mem_ready)    nxt = S_DECODE;
                else if (expired) trap_nxt = TC_TIMEOUT;
            S_DECODE:
                case (opcode)
                    OP_LOAD, OP_STORE:
                        if (ls_funct3_ok(opcode == OP_STORE, funct3, RV64)) nxt = S_MEM_ADDR;
                        else                                              trap_nxt = TC_FUNCT3;
                    OP_R:             nxt = S_R_EX;
                    OP_BRANCH:        nxt = S_BR_EX;
                    OP_JAL:           nxt = S_JAL_EX;
                    OP_JALR:          nxt = S_JALR_EX;
                    OP_IMM:           nxt = S_I_EX;
                    OP_LUI, OP_AUIPC: nxt = S_U_EX;
                    default:          trap_nxt = TC_OPCODE;
                endcase
            S_MEM_ADDR: nxt = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:
                if (mem_ready)    nxt = S_LD_WB;
                else if (expired) trap_nxt = TC_TIMEOUT;
            S_MEM_WR:
                if (mem_ready)    complete = 1'b1;
                else if (expired) trap_nxt = TC_TIMEOUT;
            S_R_EX, S_I_EX:       nxt = S_ALU_WB;
            S_JAL_EX, S_JALR_EX:  nxt = S_LINK_WB;
            S_U_EX:               nxt = S_U_WB;
            S_LD_WB, S_ALU_WB, S_BR_EX, S_LINK_WB, S_U_WB: complete = 1'b1;
            S_HALTED: if (!halt_req) nxt = S_FETCH;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_BOOT;
        endcase
        if (trap_nxt != TC_NONE)
            nxt = S_TRAP;
        if (complete)
            nxt = halt_req ? S_HALTED : S_FETCH;
    end

    always_comb begin
        PCWrite        = 1'b0;
        IRWrite        = 1'b0;
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        RegWrite       = 1'b0;
        MemtoReg       = 1'b0;
        RegDst         = 1'b0;
        ALUSrc1        = 1'b0;
        ALUSrc2        = 1'b0;
        Jump           = 1'b0;
        Branch         = 1'b0;
        JALorJALR      = 1'b0;
        Concat_control = CC_NONE;
        BE             = '0;
        ALUOp          = opcode;
        case (cur)
            S_BOOT, S_HALTED, S_TRAP: ALUOp = 7'd0;
            // PC and IR capture the fetched word on the cycle memory responds.
            S_FETCH: begin
                MemRead = 1'b1;
                PCWrite = mem_ready;
                IRWrite = mem_ready;
            end
            S_MEM_ADDR: begin
                ALUSrc2        = 1'b1;
                Concat_control = (opcode == OP_STORE) ? CC_S : CC_I;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                BE      = be_mask(funct3[1:0]);
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                BE       = be_mask(funct3[1:0]);
            end
            S_LD_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_I_EX: begin
                ALUSrc2        = 1'b1;
                Concat_control = (funct3[1:0] == 2'b01) ? CC_SHAMT : CC_I;
            end
            S_BR_EX: begin
                Branch         = 1'b1;
                Concat_control = CC_B;
            end
            S_JAL_EX: begin
                Jump           = 1'b1;
                ALUSrc1        = 1'b1;
                ALUSrc2        = 1'b1;
                Concat_control = CC_J;
            end
            S_JALR_EX: begin
                Jump           = 1'b1;
                JALorJALR      = 1'b1;
                ALUSrc2        = 1'b1;
                Concat_control = CC_I;
            end
            S_U_EX: begin
                ALUSrc1        = 1'b1;
                ALUSrc2        = 1'b1;
                Concat_control = CC_U;
            end
            S_ALU_WB, S_LINK_WB, S_U_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            default: ;
        endcase
    end

    assign state  = cur;
    assign halted = (cur == S_HALTED);
    assign trap   = (cur == S_TRAP);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: a per-instruction path model queues the
// expected per-cycle outputs, a negedge monitor compares them.
module tb_mc_control_fsm;
    import mc_pkg::*;

    localparam int XLEN = 32, TIMEOUT = 4, CNT_W = 32, VW = 67;
    localparam int P_PCW = 11, P_IRW = 10, P_MR = 9, P_MW = 8, P_RW = 7, P_M2R = 6;
    localparam int P_RD = 5, P_S1 = 4, P_S2 = 3, P_J = 2, P_BR = 1, P_JJ = 0;

    logic CLK = 1'b0, RSTn = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic mem_ready = 1'b0, halt_req = 1'b0;
    logic PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg, RegDst;
    logic ALUSrc1, ALUSrc2, Jump, Branch, JALorJALR;
    logic [6:0] ALUOp;
    logic [2:0] Concat_control;
    logic [XLEN/8-1:0] BE;
    logic [4:0] state;
    logic halted, trap;
    logic [1:0] trap_cause;
    logic [CNT_W-1:0] instret;

    mc_control_fsm #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RSTn(RSTn), .opcode(opcode), .funct3(funct3),
        .mem_ready(mem_ready), .halt_req(halt_req),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .Jump(Jump), .Branch(Branch),
        .JALorJALR(JALorJALR), .ALUOp(ALUOp), .Concat_control(Concat_control),
        .BE(BE), .state(state), .halted(halted), .trap(trap),
        .trap_cause(trap_cause), .instret(instret)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0, n_fail = 0;
    logic [VW-1:0] sb[$];
    logic [6:0]  cur_op = '0;
    logic [2:0]  cur_f3 = '0;
    logic [31:0] m_instret = '0;
    logic [1:0]  m_cause = '0;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [3:0] sz_be(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'h1;
            2'b01:   return 4'h3;
            2'b10:   return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    // Expected output picture of one cycle spent in state st.
    function automatic logic [VW-1:0] mk(input int st, input logic mr);
        logic [11:0] c;
        logic [2:0]  cc;
        logic [3:0]  be;
        logic [6:0]  aop;
        c = '0; cc = '0; be = '0;
        aop = (st == 0 || st == 16 || st == 17) ? 7'd0 : cur_op;
        case (st)
            1:  begin c[P_PCW] = mr; c[P_IRW] = mr; c[P_MR] = 1'b1; end
            3:  begin c[P_S2] = 1'b1; cc = (cur_op == OP_STORE) ? 3'd5 : 3'd3; end
            4:  begin c[P_MR] = 1'b1; be = sz_be(cur_f3); end
            5:  begin c[P_RW] = 1'b1; c[P_M2R] = 1'b1; end
            6:  begin c[P_MW] = 1'b1; be = sz_be(cur_f3); end
            9:  begin c[P_BR] = 1'b1; cc = 3'd4; end
            10: begin c[P_J] = 1'b1; c[P_S1] = 1'b1; c[P_S2] = 1'b1; cc = 3'd2; end
            11: begin c[P_J] = 1'b1; c[P_JJ] = 1'b1; c[P_S2] = 1'b1; cc = 3'd3; end
            13: begin c[P_S2] = 1'b1; cc = (cur_f3 == 3'b001 || cur_f3 == 3'b101) ? 3'd6 : 3'd3; end
            14: begin c[P_S1] = 1'b1; c[P_S2] = 1'b1; cc = 3'd1; end
            8, 12, 15: begin c[P_RW] = 1'b1; c[P_RD] = 1'b1; end
            default: ;
        endcase
        return {5'(st), c, cc, be, aop, m_instret, st == 17, st == 16,
                (st == 17) ? m_cause : 2'b00};
    endfunction

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: every queued cycle is compared half a clock after it is issued.
    always @(negedge CLK) begin
        if (sb.size() > 0)
            check("cycle_outputs",
                  {state, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg, RegDst,
                   ALUSrc1, ALUSrc2, Jump, Branch, JALorJALR, Concat_control, BE, ALUOp,
                   instret, trap, halted, trap_cause},
                  sb.pop_front());
    end

    task automatic step(input int st, input logic mr, input logic hr);
        mem_ready = mr; halt_req = hr; opcode = cur_op; funct3 = cur_f3;
        sb.push_back(mk(st, mr));
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        RSTn = 1'b0; m_instret = '0; m_cause = 2'b00;
        step(0, rb(), rb());
        step(0, rb(), rb());
        RSTn = 1'b1;
        step(0, rb(), rb());
    endtask

    task automatic trap_hold(input logic [1:0] cause);
        m_cause = cause;
        repeat (3) step(17, rb(), rb());
        do_reset();
    endtask

    // Completion: retire, then optionally sit in HALTED for hc cycles.
    task automatic complete(input int st, input int hc);
        step(st, 1'b1, hc > 0);
        m_instret++;
        if (hc > 0) begin
            for (int i = 1; i < hc; i++) step(16, rb(), 1'b1);
            step(16, rb(), 1'b0);
        end
    endtask

    task automatic do_instr(input logic [6:0] op, input logic [2:0] f3,
                            input int fw, input int mw, input int hc);
        logic [7:0] ld_ok, st_ok;
        ld_ok = 8'b0011_0111; st_ok = 8'b0000_0111;
        cur_op = op; cur_f3 = f3;
        repeat (fw) step(1, 1'b0, rb());
        step(1, 1'b1, rb());
        step(2, rb(), rb());
        if (op == OP_LOAD || op == OP_STORE) begin
            if (!((op == OP_LOAD) ? ld_ok[f3] : st_ok[f3])) begin
                trap_hold(2'b10);
                return;
            end
            step(3, rb(), rb());
            if (op == OP_LOAD) begin
                repeat (mw) step(4, 1'b0, rb());
                step(4, 1'b1, rb());
                complete(5, hc);
            end else begin
                repeat (mw) step(6, 1'b0, rb());
                complete(6, hc);
            end
        end else begin
            case (op)
                OP_R:             begin step(7, rb(), rb());  complete(8, hc);  end
                OP_IMM:           begin step(13, rb(), rb()); complete(8, hc);  end
                OP_BRANCH:        complete(9, hc);
                OP_JAL:           begin step(10, rb(), rb()); complete(12, hc); end
                OP_JALR:          begin step(11, rb(), rb()); complete(12, hc); end
                OP_LUI, OP_AUIPC: begin step(14, rb(), rb()); complete(15, hc); end
                default:          trap_hold(2'b01);
            endcase
        end
    endtask

    logic [6:0] ops [12];

    initial begin
        ops = '{OP_LOAD, OP_STORE, OP_R, OP_BRANCH, OP_JAL, OP_JALR, OP_IMM,
                OP_LUI, OP_AUIPC, 7'b1110011, 7'b0001111, 7'b1111111};
        @(posedge CLK); #1;
        do_reset();

        // ADD, ADDI, LUI back to back with memory always ready
        do_instr(OP_R,   3'b000, 0, 0, 0);
        do_instr(OP_IMM, 3'b000, 0, 0, 0);
        do_instr(OP_LUI, 3'b000, 0, 0, 0);
        // LW with three wait cycles, then a timeout-boundary store
        do_instr(OP_LOAD,  3'b010, 0, 3, 0);
        do_instr(OP_STORE, 3'b001, 4, 4, 0);
        do_instr(OP_IMM,   3'b101, 0, 0, 0);
        // halt during BR_EX, released after three HALTED cycles
        do_instr(OP_BRANCH, 3'b000, 0, 0, 3);
        do_instr(OP_JAL, 3'b000, 0, 0, 1);
        // illegal load funct3 on RV32, then illegal opcode
        do_instr(OP_LOAD, 3'b011, 0, 0, 0);
        do_instr(OP_R, 3'b000, 0, 0, 0);
        do_instr(7'b1110011, 3'b000, 0, 0, 0);

        // fetch stuck: five FETCH cycles then TRAP(11)
        cur_op = OP_R; cur_f3 = 3'b000;
        repeat (5) step(1, 1'b0, 1'b0);
        trap_hold(2'b11);

        // memory read timeout
        cur_op = OP_LOAD; cur_f3 = 3'b000;
        step(1, 1'b1, 1'b0); step(2, 1'b0, 1'b0); step(3, 1'b0, 1'b0);
        repeat (5) step(4, 1'b0, 1'b0);
        trap_hold(2'b11);

        // asynchronous reset in the middle of MEM_WR
        do_instr(OP_R, 3'b000, 0, 0, 0);
        cur_op = OP_STORE; cur_f3 = 3'b010;
        step(1, 1'b1, 1'b0); step(2, 1'b0, 1'b0); step(3, 1'b0, 1'b0);
        mem_ready = 1'b0;
        #1 check("mem_wr_entered", {59'd0, state, MemWrite, 2'b0}, {59'd0, 5'd6, 1'b1, 2'b0});
        RSTn = 1'b0;
        #1 check("async_reset", {27'd0, state, MemWrite, instret},
                 {27'd0, 5'd0, 1'b0, 32'd0});
        @(posedge CLK); #1;
        m_instret = '0; m_cause = 2'b00;
        step(0, 1'b0, 1'b0);
        RSTn = 1'b1;
        step(0, 1'b0, 1'b0);

        for (int n = 0; n < 250; n++) begin
            do_instr(ops[$urandom_range(0, 11)], 3'($urandom),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                     $urandom_range(0, 4),
                     ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
        end

        @(negedge CLK); #1;
        if (sb.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
